// File: rtl/bitwise_unit_pipe.sv
// bitwise_unit_pipe: registered 8-op bitwise unit feeding a 2-entry output FIFO
// with valid/ready handshakes on both sides and a wrapping delivered-result counter.
module bitwise_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_res;
  logic             w_acc;
  logic             w_pop;
  logic [1:0]       w_occ_nxt;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] w_tail_nxt;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_head;
  assign zero      = r_zero;
  assign xfer_cnt  = r_cnt;

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_out_valid & out_ready;

  // Bitwise operation selected by op
  always_comb begin
    w_res = '0;
    case (op_e'(op))
      OP_NOT:  w_res = ~a;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_PASS: w_res = a;
      default: w_res = '0;
    endcase
  end

  // Next FIFO state; head is the output register, so a pop leaving the FIFO
  // empty keeps the last head value visible
  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case ({w_acc, w_pop})
      2'b10: begin
        if (r_occ == 2'd0) w_head_nxt = w_res;
        else               w_tail_nxt = w_res;
        w_occ_nxt = r_occ + 2'd1;
      end
      2'b01: begin
        if (r_occ == 2'd2) w_head_nxt = r_tail;
        w_occ_nxt = r_occ - 2'd1;
      end
      2'b11: begin
        // accept requires occ<2 and pop requires occ>0, so occ is 1 here
        w_head_nxt = w_res;
      end
      default: ;
    endcase
  end

  // FIFO storage, registered handshake flags, zero flag and delivery counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_occ       <= w_occ_nxt;
      r_in_ready  <= (w_occ_nxt != 2'd2);
      r_out_valid <= (w_occ_nxt != 2'd0);
      r_zero      <= (w_occ_nxt != 2'd0) && (w_head_nxt == '0);
      r_cnt       <= r_cnt + CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Bench for bitwise_unit_pipe (WIDTH=8, CNT_W=4): table of op vectors with
// hand-computed results plus directed backpressure/streaming/reset/wrap sequences.
module tb_bitwise_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       zero;
  logic [3:0] xfer_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // expected-state model
  logic [7:0] q[$];
  logic [7:0] m_last;
  logic [3:0] m_cnt;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_zero;
  } vec_t;

  vec_t tv[10];

  bitwise_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check all outputs #1 after the edge
  task automatic step(input logic v, input logic [2:0] o, input logic [7:0] aa,
                      input logic [7:0] bb, input logic [7:0] exp_res,
                      input logic ordy, input string tag);
    logic acc, pop;
    in_valid = v; op = o; a = aa; b = bb; out_ready = ordy;
    if (!rst_n) begin
      q.delete(); m_cnt = 4'd0; m_last = 8'h00;
    end else begin
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && ordy;
      if (pop) begin
        m_last = q.pop_front();
        m_cnt  = m_cnt + 4'd1;
      end
      if (acc) q.push_back(exp_res);
      if (q.size() > 0) m_last = q[0];
    end
    @(posedge clk); #1;
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, q.size() < 2});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk({tag, ".out"},       {24'd0, out},       {24'd0, m_last});
    if (q.size() > 0) chk({tag, ".zero"}, {31'd0, zero}, {31'd0, m_last == 8'h00});
    chk({tag, ".xfer_cnt"}, {28'd0, xfer_cnt}, {28'd0, m_cnt});
  endtask

  initial begin
    tv[0] = '{3'b000, 8'hAA, 8'h3C, 8'h55, 1'b0};
    tv[1] = '{3'b001, 8'hAA, 8'h3C, 8'h28, 1'b0};
    tv[2] = '{3'b010, 8'hAA, 8'h3C, 8'hBE, 1'b0};
    tv[3] = '{3'b011, 8'hAA, 8'h3C, 8'h96, 1'b0};
    tv[4] = '{3'b100, 8'hAA, 8'h3C, 8'hD7, 1'b0};
    tv[5] = '{3'b101, 8'hAA, 8'h3C, 8'h41, 1'b0};
    tv[6] = '{3'b110, 8'hAA, 8'h3C, 8'h69, 1'b0};
    tv[7] = '{3'b111, 8'hAA, 8'h3C, 8'hAA, 1'b0};
    tv[8] = '{3'b000, 8'hFF, 8'h00, 8'h00, 1'b1};
    tv[9] = '{3'b000, 8'h12, 8'h00, 8'hED, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; out_ready = 1'b1;
    m_last = 8'h00; m_cnt = 4'd0;

    // reset for two edges, inputs active but ignored
    step(1'b1, 3'b111, 8'h5A, 8'h00, 8'h5A, 1'b1, "rst0");
    step(1'b1, 3'b111, 8'h5A, 8'h00, 8'h5A, 1'b1, "rst1");
    chk("rst.zero", {31'd0, zero}, 32'd0);
    rst_n = 1'b1;

    // all ops, one per cycle, plus the NOT zero/nonzero cases
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tv[i].op, tv[i].a, tv[i].b, tv[i].exp_out, 1'b1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_out", i),  {24'd0, out},  {24'd0, tv[i].exp_out});
      chk($sformatf("vec%0d.tbl_zero", i), {31'd0, zero}, {31'd0, tv[i].exp_zero});
    end
    // drain; op is junk while in_valid is low
    step(1'b0, 3'bxxx, 8'hxx, 8'hxx, 8'h00, 1'b1, "drain");
    chk("table.cnt", {28'd0, xfer_cnt}, 32'd10);
    chk("drain.hold", {24'd0, out}, 32'h0000_00ED);

    // backpressure: three NOTs with downstream stalled
    step(1'b1, 3'b000, 8'h00, 8'h00, 8'hFF, 1'b0, "bp0");
    step(1'b1, 3'b000, 8'h0F, 8'h00, 8'hF0, 1'b0, "bp1");
    chk("bp.full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b000, 8'hF0, 8'h00, 8'h0F, 1'b0, $sformatf("bp_hold%0d", i));
      chk($sformatf("bp_hold%0d.stable", i), {24'd0, out}, 32'h0000_00FF);
    end
    step(1'b1, 3'b000, 8'hF0, 8'h00, 8'h0F, 1'b1, "bp_rel0");
    chk("bp_rel0.out", {24'd0, out}, 32'h0000_00F0);
    step(1'b1, 3'b000, 8'hF0, 8'h00, 8'h0F, 1'b1, "bp_rel1");
    chk("bp_rel1.out", {24'd0, out}, 32'h0000_000F);
    step(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, "bp_rel2");
    chk("bp.empty", {31'd0, out_valid}, 32'd0);

    // simultaneous accept+pop at occupancy 1
    step(1'b1, 3'b111, 8'h80, 8'h00, 8'h80, 1'b1, "sim_fill");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b111, 8'(8'h81 + i), 8'h00, 8'(8'h81 + i), 1'b1, $sformatf("sim%0d", i));
      chk($sformatf("sim%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    step(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, "sim_drain");

    // fill the FIFO, then reset for one edge
    step(1'b1, 3'b111, 8'hC3, 8'h00, 8'hC3, 1'b0, "full0");
    step(1'b1, 3'b111, 8'h3C, 8'h00, 8'h3C, 1'b0, "full1");
    rst_n = 1'b0;
    step(1'b1, 3'b111, 8'h77, 8'h00, 8'h77, 1'b1, "midrst");
    chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    step(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, "post_rst0");
    step(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, "post_rst1");

    // counter wrap: 17 pops on a 4-bit counter
    for (int i = 0; i < 18; i++)
      step(1'b1, 3'b111, 8'(i + 1), 8'h00, 8'(i + 1), 1'b1, $sformatf("wrap%0d", i));
    chk("wrap.cnt17", {28'd0, xfer_cnt}, 32'd1);
    step(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, "wrap_drain");
    chk("wrap.cnt18", {28'd0, xfer_cnt}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
